// File: rtl/ama_riscv_uart.sv
// ama_riscv_uart: MMIO UART, CTRL/RX/TX registers, 1-cycle reads.
// Define UART_LOOPBACK_EN to feed TX into RX and park serial_out high.
package ama_riscv_uart_pkg;

  typedef enum logic [31:0] {
    BR_9600   = 32'd9600,
    BR_19200  = 32'd19200,
    BR_38400  = 32'd38400,
    BR_57600  = 32'd57600,
    BR_115200 = 32'd115200,
    BR_230400 = 32'd230400,
    BR_460800 = 32'd460800,
    BR_921600 = 32'd921600
  } uart_baud_rate_t;

  typedef enum logic {
    DMEM_READ  = 1'b0,
    DMEM_WRITE = 1'b1
  } dmem_rtype_t;

  typedef enum logic [1:0] {
    UART_CTRL = 2'd0,
    UART_RX   = 2'd1,
    UART_TX   = 2'd2,
    UART_RSVD = 2'd3
  } uart_addr_t;

  typedef struct packed {
    logic rx_valid;
    logic tx_ready;
  } uart_ctrl_t;

endpackage

module ama_riscv_uart
  import ama_riscv_uart_pkg::*;
#(
  parameter int unsigned     CLOCK_FREQ = 100_000_000,
  parameter uart_baud_rate_t BAUD_RATE  = BR_115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  dmem_rtype_t req_rtype,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  input  logic        serial_in,
  output logic        serial_out
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("ama_riscv_uart: CLKS_PER_BIT must be >= 4");
  end

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  uart_addr_t    addr;
  uart_ctrl_t    ctrl;
  logic          rd_en;
  logic          tx_wr;
  logic [31:0]   rd_data;

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_last;
  logic          tx_ready;
  logic          tx_line;

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_last;
  logic          rx_done;
  logic          rx_src;
  logic          rx_line;
  logic          rx_fall;

  logic          sync1_q, sync2_q, rx_prev_q;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          unused_bits;

`ifdef UART_LOOPBACK_EN
  assign rx_src      = tx_line;
  assign serial_out  = 1'b1;
  assign unused_bits = ^{serial_in, req_addr[1:0], req_wdata[31:8]};
`else
  assign rx_src      = serial_in;
  assign serial_out  = tx_line;
  assign unused_bits = ^{req_addr[1:0], req_wdata[31:8]};
`endif

  assign req_ready = 1'b1;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  assign addr  = uart_addr_t'(req_addr[3:2]);
  assign rd_en = req_valid && (req_rtype == DMEM_READ);
  assign tx_wr = req_valid && (req_rtype == DMEM_WRITE)
              && (addr == UART_TX);

  assign ctrl.rx_valid = rx_valid_q;
  assign ctrl.tx_ready = tx_ready;

  assign tx_last = (tx_cnt_q == CNT_LAST);
  assign rx_last = (rx_cnt_q == CNT_LAST);
  assign rx_line = sync2_q;
  assign rx_fall = rx_prev_q && !rx_line;

  // TX state register and bit-timing datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // TX next state: one bit per CLKS_PER_BIT, LSB first
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = req_wdata[7:0];
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_last) begin
          tx_cnt_d   = '0;
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_last) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: line level and ready flag from current state
  always_comb begin
    tx_ready = (tx_state_q == TX_IDLE);
    tx_line  = 1'b1;
    unique case (tx_state_q)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_shift_q[0];
      default:  tx_line = 1'b1;
    endcase
  end

  // RX state register and sampling datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: half-bit start check, then bit-centre sampling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_last) begin
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX output: byte completes on a good stop bit
  always_comb begin
    rx_done = (rx_state_q == RX_STOP) && rx_last && rx_line;
  end

  // Register read mux, sampled in the request cycle
  always_comb begin
    rd_data = '0;
    unique case (addr)
      UART_CTRL: rd_data = {30'b0, ctrl};
      UART_RX:   rd_data = {24'b0, rx_byte_q};
      default:   rd_data = '0;
    endcase
  end

  // RX holding register and read response next state
  always_comb begin
    rx_valid_d  = rx_valid_q;
    rx_byte_d   = rx_byte_q;
    rsp_valid_d = rd_en;
    rsp_data_d  = rd_en ? rd_data : '0;
    if (rd_en && (addr == UART_RX)) rx_valid_d = 1'b0;
    if (rx_done) begin
      rx_valid_d = 1'b1;
      rx_byte_d  = rx_shift_q;
    end
  end

  // Synchronizer, RX holding register and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      sync1_q     <= rx_src;
      sync2_q     <= sync1_q;
      rx_prev_q   <= sync2_q;
      rx_valid_q  <= rx_valid_d;
      rx_byte_q   <= rx_byte_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_ama_riscv_uart.sv
// tb_ama_riscv_uart: scoreboard bench for ama_riscv_uart.
// CLOCK_FREQ=1_152_000 at 115200 baud gives 10 clocks per bit.
`timescale 1ns/1ps
module tb_ama_riscv_uart;
  import ama_riscv_uart_pkg::*;

  localparam int CPB = 10;
  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_RX   = 4'h4;
  localparam logic [3:0] A_TX   = 4'h8;
  localparam logic [3:0] A_RSV  = 4'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  dmem_rtype_t req_rtype = DMEM_READ;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        serial_in = 1'b1;
  logic        serial_out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_d;

  ama_riscv_uart #(
    .CLOCK_FREQ(1_152_000),
    .BAUD_RATE (BR_115200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rtype (req_rtype),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .serial_in (serial_in),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time %0t exceeded budget", $time);
    $fatal(1);
  end

  // one bus cycle, called on a negedge; returns on the next negedge
  task automatic bus_req(input dmem_rtype_t t, input logic [3:0] a,
                         input logic [31:0] wd, input logic [31:0] ex);
    req_valid = 1'b1;
    req_rtype = t;
    req_addr  = a;
    req_wdata = wd;
    if (t == DMEM_READ) exp_q.push_back(ex);
    @(negedge clk);
    req_valid = 1'b0;
    req_rtype = DMEM_READ;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = fr[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (serial_out !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_data !== 32'h0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_outs: so=%b rv=%b rd=%h rr=%b, want 1 0 0 1",
               serial_out, rsp_valid, rsp_data, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    bus_req(DMEM_READ, A_CTRL, '0, 32'h1);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL reset_ctrl: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rsp_one_cycle: got v=%b, want v=0", rsp_valid);
    end
  endtask

  task automatic test_regs();
    bus_req(DMEM_WRITE, A_RX, 32'hFF, '0);
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL write_no_rsp: got v=%b, want v=0", rsp_valid);
    end
    bus_req(DMEM_WRITE, A_CTRL, 32'hFF, '0);
    bus_req(DMEM_WRITE, A_RSV, 32'hFF, '0);
    bus_req(DMEM_READ, A_RX, '0, 32'h0);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL rx_ignored_wr: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    bus_req(DMEM_READ, A_RSV, '0, 32'h0);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL rsv_read: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    bus_req(DMEM_READ, A_CTRL, '0, 32'h1);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL ctrl_ignored_wr: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
  endtask

  task automatic test_tx();
    logic [9:0] fr;
    logic       el;
    fr = {1'b1, 8'hA5, 1'b0};
    bus_req(DMEM_WRITE, A_TX, 32'hA5, '0);
    for (int k = 0; k < 120; k++) begin
      el = (k < 100) ? fr[k / CPB] : 1'b1;
      n_vec++;
      if (serial_out !== el) begin
        n_err++;
        $display("FAIL tx_line[%0d]: got %b, want %b", k, serial_out, el);
      end
      if (k == 50) begin
        bus_req(DMEM_WRITE, A_TX, 32'hFF, '0);
        n_vec++;
        if (rsp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL tx_drop_rsp: got v=%b, want 0", rsp_valid);
        end
      end else begin
        bus_req(DMEM_READ, A_CTRL, '0, {31'b0, k >= 100});
        n_vec++;
        exp_d = exp_q.pop_front();
        if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
          n_err++;
          $display("FAIL tx_ready[%0d]: got v=%b d=%h, want v=1 d=%h",
                   k, rsp_valid, rsp_data, exp_d);
        end
      end
    end
  endtask

  task automatic test_rx();
    send_serial(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    bus_req(DMEM_WRITE, A_TX, 32'h00, '0);
    bus_req(DMEM_READ, A_CTRL, '0, 32'h2);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL rx_ctrl_busy: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    bus_req(DMEM_READ, A_RX, '0, 32'h3C);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL rx_byte: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    repeat (110) @(negedge clk);
    bus_req(DMEM_READ, A_CTRL, '0, 32'h1);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL rx_cleared: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    send_serial(8'h11, 1'b1);
    send_serial(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    bus_req(DMEM_READ, A_CTRL, '0, 32'h3);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL ovr_ctrl: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    bus_req(DMEM_READ, A_RX, '0, 32'h22);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL ovr_byte: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    send_serial(8'h55, 1'b0);
    repeat (12) @(negedge clk);
    bus_req(DMEM_READ, A_CTRL, '0, 32'h1);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL frm_ctrl: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    bus_req(DMEM_READ, A_RX, '0, 32'h22);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL frm_byte: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
  endtask

  task automatic test_glitch_reset();
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (120) @(negedge clk);
    bus_req(DMEM_READ, A_CTRL, '0, 32'h1);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL glitch: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    send_serial(8'h99, 1'b1);
    repeat (2) @(negedge clk);
    bus_req(DMEM_WRITE, A_TX, 32'hA5, '0);
    repeat (40) @(negedge clk);
    n_vec++;
    if (serial_out !== 1'b0) begin
      n_err++;
      $display("FAIL pre_rst_line: got %b, want 0", serial_out);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (serial_out !== 1'b1) begin
      n_err++;
      $display("FAIL rst_line: got %b, want 1", serial_out);
    end
    rst = 1'b0;
    bus_req(DMEM_READ, A_CTRL, '0, 32'h1);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL rst_ctrl: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    bus_req(DMEM_READ, A_RX, '0, 32'h0);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL rst_byte: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (serial_out !== 1'b1) begin
      n_err++;
      $display("FAIL rst_idle_line: got %b, want 1", serial_out);
    end
  endtask

  task automatic test_loopback();
    bus_req(DMEM_WRITE, A_TX, 32'h7E, '0);
    for (int k = 0; k < 115; k++) begin
      n_vec++;
      if (serial_out !== 1'b1) begin
        n_err++;
        $display("FAIL lb_line[%0d]: got %b, want 1", k, serial_out);
      end
      @(negedge clk);
    end
    bus_req(DMEM_READ, A_CTRL, '0, 32'h3);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL lb_ctrl: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
    bus_req(DMEM_READ, A_RX, '0, 32'h7E);
    n_vec++;
    exp_d = exp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
      n_err++;
      $display("FAIL lb_byte: got v=%b d=%h, want v=1 d=%h",
               rsp_valid, rsp_data, exp_d);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`else
    test_tx();
    test_rx();
    test_back_to_back();
    test_glitch_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
